int_acc_stage: RTL and testbench

//   Accumulation stage directly downstream of the combinational signed multiplier in the CNN datapath.
//   - Consumes a stream of signed products over a valid/ready handshake.
//   - Sums each group (one kernel window / dot product), starting from a per-group bias.
//   - Saturates the sum to DATA_WIDTH, optionally applies ReLU, and presents one result per group.

---
 rtl/int_acc_stage_pkg.sv | 13 +
 rtl/int_acc_stage_sat.sv | 24 ++
 rtl/int_acc_stage.sv | 123 ++++++++++++
 tb/tb_int_acc_stage.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/int_acc_stage_pkg.sv
// Shared types and datapath defaults for the CNN integer accumulation stage.
package int_acc_stage_pkg;

  typedef enum logic {
    S_ACC = 1'b0,
    S_OUT = 1'b1
  } acc_state_e;

  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_ACC_WIDTH  = 40;
  localparam int DEF_MAX_LEN    = 256;

endpackage

// File: rtl/int_acc_stage_sat.sv
// Combinational signed clamp from IN_W to OUT_W bits with an overflow flag.
module int_sat #(
  parameter int IN_W  = 40,
  parameter int OUT_W = 32
) (
  input  logic [IN_W-1:0]  in_i,
  output logic [OUT_W-1:0] out_o,
  output logic             ovf_o
);

  // The value fits when every bit from the output sign position upward agrees.
  logic [IN_W-OUT_W:0] top;
  assign top   = in_i[IN_W-1:OUT_W-1];
  assign ovf_o = !((&top) || !(|top));

  always_comb begin
    out_o = in_i[OUT_W-1:0];
    if (ovf_o) begin
      if (in_i[IN_W-1]) out_o = {1'b1, {(OUT_W-1){1'b0}}};
      else              out_o = {1'b0, {(OUT_W-1){1'b1}}};
    end
  end

endmodule

// File: rtl/int_acc_stage.sv
// Accumulates grouped signed products from the bias, then saturates, applies
// optional ReLU and holds one result per group until the consumer takes it.
module int_acc_stage
  import int_acc_stage_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ACC_WIDTH  = DEF_ACC_WIDTH,
  parameter int MAX_LEN    = DEF_MAX_LEN
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic [DATA_WIDTH-1:0] in_prod_i,
  input  logic                  in_last_i,
  input  logic [DATA_WIDTH-1:0] cfg_bias_i,
  input  logic                  cfg_relu_i,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [DATA_WIDTH-1:0] out_data_o,
  output logic                  out_ovf_o,
  output logic                  out_err_o
);

  localparam int CW = $clog2(MAX_LEN + 1);

  acc_state_e            state_q, state_d;
  logic [ACC_WIDTH-1:0]  acc_q, acc_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  first_q, first_d;
  logic                  relu_q, relu_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic                  out_ovf_q, out_ovf_d;
  logic                  out_err_q, out_err_d;

  logic                  beat;
  logic                  relu_eff;
  logic                  close;
  logic [CW-1:0]         cnt_inc;
  logic [ACC_WIDTH-1:0]  prod_ext;
  logic [ACC_WIDTH-1:0]  bias_ext;
  logic [ACC_WIDTH-1:0]  acc_next;
  logic [DATA_WIDTH-1:0] sat_val;
  logic                  sat_ovf;

  assign in_ready_o  = (state_q == S_ACC);
  assign out_valid_o = (state_q == S_OUT);
  assign out_data_o  = out_data_q;
  assign out_ovf_o   = out_ovf_q;
  assign out_err_o   = out_err_q;

  assign beat     = in_valid_i && in_ready_o;
  assign prod_ext = ACC_WIDTH'(signed'(in_prod_i));
  assign bias_ext = ACC_WIDTH'(signed'(cfg_bias_i));
  assign acc_next = (first_q ? bias_ext : acc_q) + prod_ext;
  assign cnt_inc  = cnt_q + 1'b1;
  assign close    = in_last_i || (cnt_inc == CW'(MAX_LEN));
  // A single-beat group closes before relu_q has been loaded.
  assign relu_eff = first_q ? cfg_relu_i : relu_q;

  int_sat #(
    .IN_W  (ACC_WIDTH),
    .OUT_W (DATA_WIDTH)
  ) u_sat (
    .in_i  (acc_next),
    .out_o (sat_val),
    .ovf_o (sat_ovf)
  );

  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    first_d    = first_q;
    relu_d     = relu_q;
    out_data_d = out_data_q;
    out_ovf_d  = out_ovf_q;
    out_err_d  = out_err_q;
    if (state_q == S_ACC) begin
      if (beat) begin
        acc_d   = acc_next;
        cnt_d   = cnt_inc;
        first_d = 1'b0;
        if (first_q) relu_d = cfg_relu_i;
        if (close) begin
          out_data_d = (relu_eff && sat_val[DATA_WIDTH-1]) ? '0 : sat_val;
          out_ovf_d  = sat_ovf;
          out_err_d  = !in_last_i;
          state_d    = S_OUT;
        end
      end
    end else begin
      if (out_ready_i) begin
        state_d = S_ACC;
        first_d = 1'b1;
        cnt_d   = '0;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= S_ACC;
      acc_q      <= '0;
      cnt_q      <= '0;
      first_q    <= 1'b1;
      relu_q     <= 1'b0;
      out_data_q <= '0;
      out_ovf_q  <= 1'b0;
      out_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      first_q    <= first_d;
      relu_q     <= relu_d;
      out_data_q <= out_data_d;
      out_ovf_q  <= out_ovf_d;
      out_err_q  <= out_err_d;
    end
  end

endmodule

// File: tb/tb_int_acc_stage.sv
// Bench for int_acc_stage at DATA_WIDTH=8, ACC_WIDTH=16, MAX_LEN=4: vector table,
// directed corner sequences, then random traffic against an arithmetic model.
module tb_int_acc_stage;

  localparam int DW = 8;
  localparam int AW = 16;
  localparam int ML = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_prod;
  logic          in_last;
  logic [DW-1:0] cfg_bias;
  logic          cfg_relu;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic          out_ovf;
  logic          out_err;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  int_acc_stage #(.DATA_WIDTH(DW), .ACC_WIDTH(AW), .MAX_LEN(ML)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .in_prod_i   (in_prod),
    .in_last_i   (in_last),
    .cfg_bias_i  (cfg_bias),
    .cfg_relu_i  (cfg_relu),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .out_data_o  (out_data),
    .out_ovf_o   (out_ovf),
    .out_err_o   (out_err)
  );

  typedef struct {
    string name;
    int    bias;
    bit    relu;
    int    len;
    int    p[4];
    int    exp_data;
    bit    exp_ovf;
    bit    exp_err;
  } vec_t;

  typedef struct {
    int data;
    bit ovf;
    bit err;
  } res_t;

  vec_t vecs[$];
  res_t exp_q[$];

  task automatic check(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic add_vec(input string nm, input int b, input bit r, input int len,
                         input int p0, input int p1, input int p2, input int p3,
                         input int ed, input bit eo, input bit ee);
    vec_t v;
    v.name = nm; v.bias = b; v.relu = r; v.len = len;
    v.p[0] = p0; v.p[1] = p1; v.p[2] = p2; v.p[3] = p3;
    v.exp_data = ed; v.exp_ovf = eo; v.exp_err = ee;
    vecs.push_back(v);
  endtask

  // Whole-group reference: wrap to the accumulator width, clamp, then ReLU.
  function automatic res_t model_res(input int s, input bit relu, input bit last);
    res_t r;
    int w, sat;
    w   = int'(shortint'(s));
    sat = (w > 127) ? 127 : (w < -128) ? -128 : w;
    r.ovf  = (sat != w);
    r.data = (relu && sat < 0) ? 0 : sat;
    r.err  = !last;
    return r;
  endfunction

  task automatic send_beat(input int p, input bit last, input int b, input bit r);
    int t;
    t = 0;
    @(negedge clk);
    in_valid = 1'b1; in_prod = DW'(p); in_last = last; cfg_bias = DW'(b); cfg_relu = r;
    while (!in_ready && t < 40) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) check("beat_timeout", 0, 1);
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic get_result(input string nm, input int ed, input bit eo, input bit ee);
    int t;
    t = 0;
    while (!out_valid && t < 40) begin
      @(negedge clk);
      t++;
    end
    check({nm, "_valid"}, int'(out_valid), 1);
    check({nm, "_data"}, int'($signed(out_data)), ed);
    check({nm, "_ovf"}, int'(out_ovf), int'(eo));
    check({nm, "_err"}, int'(out_err), int'(ee));
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  initial begin
    bit m_first, m_relu, close_pend;
    int m_sum, m_cnt;
    res_t r, e;

    rst = 1'b1; in_valid = 1'b0; in_prod = '0; in_last = 1'b0;
    cfg_bias = '0; cfg_relu = 1'b0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_in_ready", int'(in_ready), 1);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_out_data", int'(out_data), 0);
    check("rst_out_ovf", int'(out_ovf), 0);
    check("rst_out_err", int'(out_err), 0);

    add_vec("basic",       2,   0, 4,    3,   -1, 10, 5,  19,   0, 0);
    add_vec("sat_pos",     0,   0, 2,  100,  100,  0, 0, 127,   1, 0);
    add_vec("sat_neg",     0,   0, 2, -100, -100,  0, 0, -128,  1, 0);
    add_vec("relu_on",     0,   1, 2,   -4,   -3,  0, 0,   0,   0, 0);
    add_vec("relu_off",    0,   0, 2,   -4,   -3,  0, 0,  -7,   0, 0);
    add_vec("single",      5,   0, 1,   -9,    0,  0, 0,  -4,   0, 0);
    add_vec("relu_sat",    0,   1, 2, -100, -100,  0, 0,   0,   1, 0);
    add_vec("relu_pos",   -3,   1, 2,   10,    4,  0, 0,  11,   0, 0);
    add_vec("sat_bias",  127,   0, 2,    1,    0,  0, 0, 127,   1, 0);
    add_vec("maxlen_last", 0,   0, 4,    1,    1,  1, 1,   4,   0, 0);

    foreach (vecs[k]) begin
      for (int i = 0; i < vecs[k].len; i++) begin
        // Later beats carry misleading cfg values that the stage must ignore.
        if (i == 0) send_beat(vecs[k].p[i], vecs[k].len == 1, vecs[k].bias, vecs[k].relu);
        else        send_beat(vecs[k].p[i], i == vecs[k].len - 1, 99, !vecs[k].relu);
      end
      check({vecs[k].name, "_latency"}, int'(out_valid), 1);
      get_result(vecs[k].name, vecs[k].exp_data, vecs[k].exp_ovf, vecs[k].exp_err);
    end

    // Backpressure: result held while out_ready stays low.
    send_beat(3, 0, 2, 0); send_beat(-1, 0, 0, 0); send_beat(10, 0, 0, 0); send_beat(5, 1, 0, 0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_valid", int'(out_valid), 1);
      check("bp_in_ready", int'(in_ready), 0);
      check("bp_data", int'($signed(out_data)), 19);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("bp_released_valid", int'(out_valid), 0);
    check("bp_released_ready", int'(in_ready), 1);
    send_beat(6, 1, 1, 0);
    get_result("bp_next", 7, 0, 0);

    // MAX_LEN force-close, then the tail of the stream forms a new group.
    for (int i = 0; i < 4; i++) send_beat(1, 0, 0, 0);
    check("maxlen_latency", int'(out_valid), 1);
    get_result("maxlen_forced", 4, 0, 1);
    send_beat(1, 0, 0, 0);
    send_beat(1, 1, 0, 0);
    get_result("maxlen_tail", 2, 0, 0);

    // Reset mid-group drops the partial sum.
    send_beat(1, 0, 50, 0);
    send_beat(2, 0, 0, 0);
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    check("rst_mid_valid", int'(out_valid), 0);
    check("rst_mid_ready", int'(in_ready), 1);
    send_beat(7, 1, 0, 0);
    get_result("rst_mid_next", 7, 0, 0);

    // Reset with a pending result discards it.
    send_beat(9, 1, 0, 0);
    @(negedge clk);
    check("rst_pend_before", int'(out_valid), 1);
    rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    check("rst_pend_valid", int'(out_valid), 0);
    send_beat(-5, 1, 1, 0);
    get_result("rst_pend_next", -4, 0, 0);

    // Random traffic: the model updates at each negedge for the edge that follows.
    m_first = 1; m_sum = 0; m_cnt = 0; m_relu = 0; close_pend = 0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if (close_pend) begin
        check("rand_latency", int'(out_valid), 1);
        close_pend = 0;
      end
      check("rand_ready_vs_valid", int'(in_ready), int'(!out_valid));
      in_valid  = ($urandom_range(0, 3) != 0);
      in_prod   = DW'($urandom);
      in_last   = ($urandom_range(0, 2) == 0);
      cfg_bias  = DW'($urandom);
      cfg_relu  = 1'($urandom);
      out_ready = ($urandom_range(0, 2) != 0);
      if (c >= 2980) begin
        in_valid = 1'b0;
        out_ready = 1'b1;
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("rand_unexpected_result", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("rand_data", int'($signed(out_data)), e.data);
          check("rand_ovf", int'(out_ovf), int'(e.ovf));
          check("rand_err", int'(out_err), int'(e.err));
        end
      end
      if (in_valid && in_ready) begin
        if (m_first) begin
          m_sum = int'($signed(cfg_bias));
          m_relu = cfg_relu;
        end
        m_sum += int'($signed(in_prod));
        m_cnt++;
        m_first = 0;
        if (in_last || m_cnt == ML) begin
          r = model_res(m_sum, m_relu, in_last);
          exp_q.push_back(r);
          m_first = 1; m_cnt = 0; close_pend = 1;
        end
      end
    end
    check("rand_drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
